// File: rtl/seg_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Used by seq_bin2bcd and its bcd_add3 digit cells.
package seg_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'h9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Shift-and-add-3 digit cell: bumps a BCD digit by 3 when it is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] in_i,
    output logic [3:0] out_o
);

    assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter, one bit per clock, for the hex displays.
// Define SEQ_BIN2BCD_BLANK_EN to build the leading-zero blank mask.
module seq_bin2bcd
    import seg_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [WIDTH-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [DIGITS*BCD_W-1:0] bcd,
    output logic                    overflow,
    output logic [DIGITS-1:0]       blank
);

    localparam int DW = DIGITS * BCD_W;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [DW-1:0]   wk_q, wk_d;
    logic [DW-1:0]   adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;

    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3 u_add3 (
            .in_i  (wk_q[k*BCD_W +: BCD_W]),
            .out_o (adj[k*BCD_W +: BCD_W])
        );
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        wk_d    = wk_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    sr_d    = bin;
                    wk_d    = '0;
                    acc_d   = 1'b0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A set MSB in the adjusted top digit would be lost by the shift.
                wk_d = {adj[DW-2:0], sr_q[WIDTH-1]};
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
                if (adj[DW-1]) begin
                    acc_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                if (acc_q) begin
                    bcd_d = {DIGITS{BCD_NINE}};
                    ovf_d = 1'b1;
                end else begin
                    bcd_d = wk_q;
                    ovf_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            wk_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            wk_q    <= wk_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bcd      = bcd_q;
    assign overflow = ovf_q;

`ifdef SEQ_BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              seen;

    // Digit 0 is never blanked so a zero value still shows "0".
    always_comb begin
        blank_d = blank_q;
        seen    = 1'b0;
        if (state_q == DONE) begin
            blank_d = '0;
            if (!acc_q) begin
                for (int k = DIGITS - 1; k > 0; k--) begin
                    seen       = seen | (wk_q[k*BCD_W +: BCD_W] != '0);
                    blank_d[k] = ~seen;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule
